// File: rtl/rom_stream_if.sv
// Control, ROM-side and stream-side signals of the rom_stream sequencer.
// master = sequencer side, slave = environment (controller, ROM, consumer).
interface rom_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned ADDRW = $clog2(DEPTH);
  localparam int unsigned LENW  = $clog2(DEPTH + 1);

  logic             start;
  logic             abort;
  logic [ADDRW-1:0] base_addr;
  logic [LENW-1:0]  len;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  start, abort, base_addr, len, rom_data, out_ready,
    output busy, done, rom_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, abort, base_addr, len, rom_data, out_ready,
    input  busy, done, rom_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_stream.sv
// Address sequencer in front of an asynchronous ROM, streaming words over valid/ready.
// Optional running checksum output enabled by defining ROM_STREAM_CSUM_EN.
module rom_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  rom_stream_if.master        bus
`ifdef ROM_STREAM_CSUM_EN
  ,
  output logic [WIDTH-1:0]    csum
`endif
);
  localparam int unsigned ADDRW = $clog2(DEPTH);
  localparam int unsigned LENW  = $clog2(DEPTH + 1);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [ADDRW-1:0] rd_addr_q,   rd_addr_d;
  logic [LENW-1:0]  remaining_q, remaining_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             done_q,      done_d;

  logic accept;
  logic load;
  logic fire;

  assign accept = (state_q == StIdle) && bus.start && !bus.abort;
  // Output register may be refilled when empty or being drained this cycle.
  assign load   = !out_valid_q || bus.out_ready;
  assign fire   = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.len != '0) begin
            state_d     = StStream;
            rd_addr_d   = bus.base_addr;
            remaining_d = bus.len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (bus.abort) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if ((remaining_q == '0) && fire) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end else if (load && (remaining_q != '0)) begin
          out_data_d  = bus.rom_data;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == LENW'(1));
          rd_addr_d   = ADDRW'(rd_addr_q + 1'b1);
          remaining_d = LENW'(remaining_q - 1'b1);
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

`ifdef ROM_STREAM_CSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  // Accumulates every accepted beat; holds after done until the next accepted burst.
  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (fire) begin
      csum_d = WIDTH'(csum_q + out_data_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  // Checksum path not built.
`endif

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.rom_addr  = rd_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: doc/rom_stream.md
Name: rom_stream

Overview:
- Address-generating sequencer that sits directly upstream of an asynchronous ROM: it drives the ROM address, captures the combinational read data, and streams words out on a valid/ready interface.
- Used to burst-copy ROM contents (boot images, tables) into downstream FIFOs or memories.
- One word per cycle when the consumer keeps ready high.

Parameters:
- WIDTH, 8, ROM data word width in bits.
- DEPTH, 256, ROM depth in words; ADDRW = $clog2(DEPTH), LENW = $clog2(DEPTH+1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a burst; sampled only in IDLE.
- abort  input  1  synchronous abort of the current burst.
- base_addr  input  ADDRW  first ROM address of the burst.
- len  input  LENW  number of words to stream, 0..DEPTH.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the final word has been accepted.
- rom_addr  output  ADDRW  address to the asynchronous ROM, driven directly from the internal address register.
- rom_data  input  WIDTH  read data returned combinationally in the same cycle.
- out_data  output  WIDTH  streamed word, registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_last  output  1  qualifies the final word of the burst.

Behaviour:
- Reset: state IDLE; rd_addr, remaining, out_data = 0; out_valid, out_last, done, busy = 0.
- States: IDLE and STREAM.
- IDLE → STREAM:
  - Condition: start=1, abort=0 and len!=0.
  - Actions: rd_addr<=base_addr, remaining<=len.
- IDLE, start=1, len==0: stay in IDLE; done pulses for one cycle on the next cycle; no out_valid.
- start while in STREAM: ignored, no queuing.
- STREAM load rule:
  - load = !out_valid || out_ready.
  - On load with remaining!=0: out_data<=rom_data, out_valid<=1, out_last<=(remaining==1), rd_addr<=rd_addr+1 (mod 2^ADDRW, wraps DEPTH-1→0), remaining<=remaining-1.
- STREAM exit:
  - Condition: remaining==0, out_valid=1 and out_ready=1 (last word accepted).
  - Actions: out_valid<=0, out_last<=0, done<=1 for one cycle, state<=IDLE.
- Latency: busy rises the clock after start is accepted; out_valid rises one clock later carrying mem[base_addr].
- Throughput: with out_ready held high, consecutive words appear on consecutive cycles with no bubbles.
- Handshake rules:
  - While out_valid=1 && out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
- abort=1 in STREAM:
  - Next cycle: state IDLE, out_valid=0, out_last=0.
  - No done pulse; any pending word is discarded.
- abort has priority over start in the same cycle.
- Asynchronous rst mid-burst returns all state and outputs to their reset values immediately.
- done and out_valid are never high in the same cycle.

Optional Feature:
- Macro: ROM_STREAM_CSUM_EN.
- When defined:
  - Adds output port csum (WIDTH).
  - csum is cleared to 0 when a burst is accepted.
  - On each accepted beat, csum<=csum+out_data (mod 2^WIDTH).
  - Final value is valid in the done cycle and holds until the next burst is accepted.
  - Reset value is 0.
- When undefined: no csum port and no checksum logic.

Test Plan:
- ROM mem[i]=i, WIDTH=8, DEPTH=256, base=0x10, len=4, out_ready=1 → out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; out_last only on 0x13; done one cycle after the 0x13 beat; busy low after.
- Same burst, out_ready pattern 0,1,0,1,0,1,0,1 → each word held stable while ready=0; exactly 4 transfers in order; no duplicates or drops.
- base=0xFE, len=4 → 0xFE,0xFF,0x00,0x01; out_last on 0x01.
- len=0 with start=1 → done pulses once, out_valid never asserted, busy stays 0.
- Abort and reset mid-burst:
  - base=0x20, len=8; abort after 2 accepted beats → out_valid=0 next cycle, no done.
  - New start base=0x40, len=1 → single word 0x40 with out_last.
  - Repeat the burst with rst asserted mid-burst → all outputs 0 immediately.
- ROM_STREAM_CSUM_EN defined, base=0x10, len=4 → csum=0x46 in the done cycle; with len=2 at base=0xFF → csum=0xFF (0xFF+0x00).
